// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment display path.
//   - seg7_t          : active-high segment vector, bit 6 = A ... bit 0 = G
//   - SEG_A..SEG_DP   : bit positions of each segment inside the 8-bit
//                       cathode bus (A in bit 7 down to DP in bit 0)
//   - HEX_SEG7_TABLE  : 16-entry hex -> segment pattern table
//   - hex_seg7()      : table lookup helper
// -----------------------------------------------------------------------------
package seg7_pkg;

  // Active-high segment pattern, {A, B, C, D, E, F, G}.
  typedef logic [6:0] seg7_t;

  // Bit positions on the 8-bit cathode bus.
  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_B  = 6;
  localparam int unsigned SEG_C  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 3;
  localparam int unsigned SEG_F  = 2;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  // Standard hex glyphs. Letters render as A, b, C, d, E, F so that
  // b/d stay distinguishable from 8/0.
  localparam seg7_t HEX_SEG7_TABLE [0:15] = '{
    7'h7E,  // 0 : A B C D E F
    7'h30,  // 1 : B C
    7'h6D,  // 2 : A B D E G
    7'h79,  // 3 : A B C D G
    7'h33,  // 4 : B C F G
    7'h5B,  // 5 : A C D F G
    7'h5F,  // 6 : A C D E F G
    7'h70,  // 7 : A B C
    7'h7F,  // 8 : all
    7'h7B,  // 9 : A B C D F G
    7'h77,  // A : A B C E F G
    7'h1F,  // b : C D E F G
    7'h4E,  // C : A D E F
    7'h3D,  // d : B C D E G
    7'h4F,  // E : A D E F G
    7'h47   // F : A E F G
  };

  function automatic seg7_t hex_seg7(input logic [3:0] nibble);
    return HEX_SEG7_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Purely combinational hex nibble to seven-segment decode.
// Ports:
//   i_nibble : 4-bit hex value
//   o_seg    : active-high segment pattern {A..G}
// -----------------------------------------------------------------------------
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg7_t      o_seg
);

  assign o_seg = hex_seg7(i_nibble);

endmodule

// File: rtl/seven_segment_mux.sv
// -----------------------------------------------------------------------------
// seven_segment_mux
// Time-multiplexed driver for a common-anode seven-segment bank.
// Each digit owns a slot of REFRESH_DIV clocks; the first BLANK_CYCLES of a
// slot keep every anode off so the cathodes can settle without ghosting.
// Inside the on-window a free-running PWM counter gates the anode to set
// brightness. All display inputs are captured once per frame (digit 0, slot
// cycle 0) so a frame never mixes old and new values.
//
// Ports:
//   clk_in         : system clock
//   rst_in         : asynchronous active-high reset
//   val_in         : nibble i = hex value of digit i (digit 0 rightmost)
//   dp_in          : decimal point request per digit
//   digit_en_in    : 1 = digit may light
//   brightness_in  : PWM duty; all ones = full on, 0 = dark
//   lz_blank_in    : enable leading-zero blanking
//   cat_out        : active-low cathodes, [7]=A .. [1]=G, [0]=DP
//   an_out         : active-low anode per digit
//   digit_idx_out  : digit currently occupying the slot
//   frame_tick_out : one-cycle pulse when the digit index wraps to 0
//
// an_out, cat_out and digit_idx_out are registered and lag the internal
// counter state by one cycle; frame_tick_out is aligned with digit_idx_out.
// -----------------------------------------------------------------------------
module seven_segment_mux
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BRIGHT_W     = 4,
  localparam int unsigned IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic [BRIGHT_W-1:0]     brightness_in,
  input  logic                    lz_blank_in,
  output logic [7:0]              cat_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [IDX_W-1:0]        digit_idx_out,
  output logic                    frame_tick_out
);

  localparam int unsigned         SLOT_W    = $clog2(REFRESH_DIV);
  localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]   SLOT_ON   = SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SLOT_W-1:0]       r_slot_cnt;
  logic [IDX_W-1:0]        r_digit_idx;
  logic [BRIGHT_W-1:0]     r_pwm_cnt;
  logic                    r_wrap_pend;

  logic [4*NUM_DIGITS-1:0] r_snap_val;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  logic [NUM_DIGITS-1:0]   r_snap_en;
  logic [BRIGHT_W-1:0]     r_snap_bright;
  logic                    r_snap_lz;

  logic [7:0]              r_cat;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [IDX_W-1:0]        r_idx_out;
  logic                    r_frame_tick;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic                    w_slot_wrap;
  logic                    w_capture;
  logic [4*NUM_DIGITS-1:0] w_val;
  logic [NUM_DIGITS-1:0]   w_dp;
  logic [NUM_DIGITS-1:0]   w_en;
  logic [BRIGHT_W-1:0]     w_bright;
  logic                    w_lz;
  logic [NUM_DIGITS-1:0]   w_upper_zero;
  logic [3:0]              w_nibble;
  logic                    w_dp_bit;
  logic                    w_en_bit;
  logic                    w_lz_zone;
  logic                    w_lz_blank;
  logic                    w_in_window;
  logic                    w_pwm_open;
  logic                    w_lit;
  seg7_t                   w_seg;
  seg7_t                   w_seg_shown;
  logic [7:0]              w_cat_next;
  logic [NUM_DIGITS-1:0]   w_an_next;

  assign w_slot_wrap = (r_slot_cnt == SLOT_LAST);
  assign w_capture   = (r_digit_idx == '0) && (r_slot_cnt == '0);

  // On the capture cycle the display path already sees the new inputs, so
  // the whole frame (including its very first cycle) uses one coherent set.
  assign w_val    = w_capture ? val_in        : r_snap_val;
  assign w_dp     = w_capture ? dp_in         : r_snap_dp;
  assign w_en     = w_capture ? digit_en_in   : r_snap_en;
  assign w_bright = w_capture ? brightness_in : r_snap_bright;
  assign w_lz     = w_capture ? lz_blank_in   : r_snap_lz;

  // ---------------------------------------------------------------------------
  // Slot / digit / PWM counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
      r_pwm_cnt   <= '0;
      r_wrap_pend <= 1'b0;
    end else begin
      r_pwm_cnt   <= r_pwm_cnt + BRIGHT_W'(1);
      // Marks the edge at which the index returns to 0; the tick output is
      // delayed one more cycle to line up with digit_idx_out.
      r_wrap_pend <= w_slot_wrap && (r_digit_idx == IDX_LAST);
      if (w_slot_wrap) begin
        r_slot_cnt  <= '0;
        r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + IDX_W'(1);
      end else begin
        r_slot_cnt  <= r_slot_cnt + SLOT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame snapshot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_snap_val    <= '0;
      r_snap_dp     <= '0;
      r_snap_en     <= '0;
      r_snap_bright <= '0;
      r_snap_lz     <= 1'b0;
    end else if (w_capture) begin
      r_snap_val    <= val_in;
      r_snap_dp     <= dp_in;
      r_snap_en     <= digit_en_in;
      r_snap_bright <= brightness_in;
      r_snap_lz     <= lz_blank_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit selection and leading-zero detection
  // ---------------------------------------------------------------------------
  // w_upper_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    w_upper_zero = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      w_upper_zero[i] = ((w_val >> (4 * i)) == '0);
    end
  end

  always_comb begin
    w_nibble  = 4'h0;
    w_dp_bit  = 1'b0;
    w_en_bit  = 1'b0;
    w_lz_zone = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (r_digit_idx == IDX_W'(i)) begin
        w_nibble  = w_val[4*i +: 4];
        w_dp_bit  = w_dp[i];
        w_en_bit  = w_en[i];
        // Digit 0 always shows its value, even when everything is zero.
        w_lz_zone = (i != 0) && w_upper_zero[i];
      end
    end
  end

  assign w_lz_blank = w_lz && w_lz_zone;

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // ---------------------------------------------------------------------------
  // Lit decision and next output values
  // ---------------------------------------------------------------------------
  assign w_in_window = (r_slot_cnt >= SLOT_ON);
  assign w_pwm_open  = (&w_bright) || (r_pwm_cnt < w_bright);

  // A leading-zero-blanked digit may still light to show its DP alone.
  assign w_lit       = w_en_bit && w_in_window && w_pwm_open &&
                       (!w_lz_blank || w_dp_bit);
  assign w_seg_shown = w_lz_blank ? '0 : w_seg;
  assign w_cat_next  = w_lit ? ~{w_seg_shown, w_dp_bit} : 8'hFF;

  always_comb begin
    w_an_next = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      w_an_next[i] = !(w_lit && (r_digit_idx == IDX_W'(i)));
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cat        <= 8'hFF;
      r_an         <= '1;
      r_idx_out    <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_cat        <= w_cat_next;
      r_an         <= w_an_next;
      r_idx_out    <= r_digit_idx;
      r_frame_tick <= r_wrap_pend;
    end
  end

  assign cat_out        = r_cat;
  assign an_out         = r_an;
  assign digit_idx_out  = r_idx_out;
  assign frame_tick_out = r_frame_tick;

endmodule

// File: tb/tb_seven_segment_mux.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_mux
// Directed bench for seven_segment_mux with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2, BRIGHT_W=4. One frame = 4 slots x 8 cycles = 32 cycles.
// Timing reference: cyc counts rising edges since reset release; after edge
// cyc the outputs reflect counter state c = (cyc-1) % 32, digit c/8,
// slot cycle c%8, PWM count (cyc-1) % 16.
// -----------------------------------------------------------------------------
module tb_seven_segment_mux;

  localparam int ND = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] val;
  logic [3:0]  dp;
  logic [3:0]  en;
  logic [3:0]  bright;
  logic        lz;
  logic [7:0]  cat;
  logic [3:0]  an;
  logic [1:0]  idx_o;
  logic        tick_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  seven_segment_mux #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2),
    .BRIGHT_W     (4)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .val_in         (val),
    .dp_in          (dp),
    .digit_en_in    (en),
    .brightness_in  (bright),
    .lz_blank_in    (lz),
    .cat_out        (cat),
    .an_out         (an),
    .digit_idx_out  (idx_o),
    .frame_tick_out (tick_o)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Run until the next edge is the first edge of a frame.
  task automatic align_frame();
    while (cyc % 32 != 0) tick();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    val = 16'h0018; dp = 4'h0; en = 4'hF; bright = 4'hF; lz = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (an !== 4'hF || cat !== 8'hFF || tick_o !== 1'b0 || idx_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold an=%h cat=%h tick=%b idx=%0d expected an=f cat=ff tick=0 idx=0",
               an, cat, tick_o, idx_o);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    #1;
    checks++;
    if (an !== 4'hF || cat !== 8'hFF) begin
      errors++;
      $display("FAIL reset_release_sync an=%h cat=%h expected an=f cat=ff", an, cat);
    end
  endtask

  // val=0018, no lz: digits show 8, 1, 0, 0. First frame after reset, no tick.
  task automatic test_scan_decode();
    logic [7:0] exp_cat;
    logic [3:0] exp_an;
    logic [7:0] glyph [4];
    int c, d, s;
    glyph[0] = 8'h01; glyph[1] = 8'h9F; glyph[2] = 8'h03; glyph[3] = 8'h03;
    for (int n = 0; n < 32; n++) begin
      tick();
      c = (cyc - 1) % 32; d = c / 8; s = c % 8;
      exp_an = 4'hF; exp_cat = 8'hFF;
      if (s >= 2) begin
        exp_an  = 4'(~(4'b0001 << d));
        exp_cat = glyph[d];
      end
      checks++;
      if (an !== exp_an || cat !== exp_cat || idx_o !== 2'(d) || tick_o !== 1'b0) begin
        errors++;
        $display("FAIL scan_decode cyc=%0d an=%h cat=%h idx=%0d tick=%b expected an=%h cat=%h idx=%0d tick=0",
                 cyc, an, cat, idx_o, tick_o, exp_an, exp_cat, d);
      end
    end
  endtask

  // Three frames: exactly one tick per frame, on the first cycle, idx=0.
  task automatic test_frame_tick();
    int ticks = 0;
    int c;
    align_frame();
    for (int n = 0; n < 96; n++) begin
      tick();
      c = (cyc - 1) % 32;
      if (tick_o === 1'b1) ticks++;
      if (c == 0) begin
        checks++;
        if (tick_o !== 1'b1 || idx_o !== 2'd0) begin
          errors++;
          $display("FAIL frame_tick_at_wrap cyc=%0d tick=%b idx=%0d expected tick=1 idx=0",
                   cyc, tick_o, idx_o);
        end
      end
    end
    checks++;
    if (ticks != 3) begin
      errors++;
      $display("FAIL frame_tick_count got=%0d expected=3", ticks);
    end
  endtask

  // lz on, val=0005, dp on digit 2: digit 0 "5", digit 2 DP only, 1 and 3 dark.
  task automatic test_lz_blank();
    logic [7:0] exp_cat;
    logic [3:0] exp_an;
    int c, d, s;
    lz = 1'b1; val = 16'h0005; dp = 4'b0100; en = 4'hF; bright = 4'hF;
    align_frame();
    for (int n = 0; n < 32; n++) begin
      tick();
      c = (cyc - 1) % 32; d = c / 8; s = c % 8;
      exp_an = 4'hF; exp_cat = 8'hFF;
      if (s >= 2 && d == 0) begin exp_an = 4'hE; exp_cat = 8'h49; end
      if (s >= 2 && d == 2) begin exp_an = 4'hB; exp_cat = 8'hFE; end
      checks++;
      if (an !== exp_an || cat !== exp_cat) begin
        errors++;
        $display("FAIL lz_blank cyc=%0d an=%h cat=%h expected an=%h cat=%h",
                 cyc, an, cat, exp_an, exp_cat);
      end
    end
  endtask

  // Mask 0101, val=4321, dp on digit 0: digit 0 "1." (9E), digit 2 "3" (0D).
  task automatic test_enable_mask();
    logic [7:0] exp_cat;
    logic [3:0] exp_an;
    int c, d, s;
    lz = 1'b0; val = 16'h4321; dp = 4'b0001; en = 4'b0101; bright = 4'hF;
    align_frame();
    for (int n = 0; n < 32; n++) begin
      tick();
      c = (cyc - 1) % 32; d = c / 8; s = c % 8;
      exp_an = 4'hF; exp_cat = 8'hFF;
      if (s >= 2 && d == 0) begin exp_an = 4'hE; exp_cat = 8'h9E; end
      if (s >= 2 && d == 2) begin exp_an = 4'hB; exp_cat = 8'h0D; end
      checks++;
      if (an !== exp_an || cat !== exp_cat) begin
        errors++;
        $display("FAIL enable_mask cyc=%0d an=%h cat=%h expected an=%h cat=%h",
                 cyc, an, cat, exp_an, exp_cat);
      end
    end
  endtask

  // Brightness 4: lit only where pwm<4 inside the on-window. Slot and PWM
  // counters share phase from reset (pwm%8 == slot), so only pwm 2 and 3 land
  // in the on-window: 4 lit cycles per 32-cycle frame, 12 over three frames.
  // Brightness 0 then keeps the display dark for a whole frame.
  task automatic test_pwm();
    logic [7:0] exp_cat;
    logic [3:0] exp_an;
    int c, d, s, pwm;
    int lit = 0;
    lz = 1'b0; val = 16'h8888; dp = 4'h0; en = 4'hF; bright = 4'h4;
    align_frame();
    for (int n = 0; n < 96; n++) begin
      tick();
      c = (cyc - 1) % 32; d = c / 8; s = c % 8; pwm = (cyc - 1) % 16;
      exp_an = 4'hF; exp_cat = 8'hFF;
      if (s >= 2 && pwm < 4) begin
        exp_an  = 4'(~(4'b0001 << d));
        exp_cat = 8'h01;
      end
      if (an !== 4'hF) lit++;
      checks++;
      if (an !== exp_an || cat !== exp_cat) begin
        errors++;
        $display("FAIL pwm_gate cyc=%0d pwm=%0d an=%h cat=%h expected an=%h cat=%h",
                 cyc, pwm, an, cat, exp_an, exp_cat);
      end
    end
    checks++;
    if (lit != 12) begin
      errors++;
      $display("FAIL pwm_duty lit_cycles=%0d expected=12", lit);
    end
    bright = 4'h0;
    lit = 0;
    align_frame();
    for (int n = 0; n < 32; n++) begin
      tick();
      if (an !== 4'hF || cat !== 8'hFF) lit++;
    end
    checks++;
    if (lit != 0) begin
      errors++;
      $display("FAIL pwm_dark lit_cycles=%0d expected=0", lit);
    end
  endtask

  // val changes 1111 -> 2222 during digit 2's slot; visible only next frame.
  task automatic test_snapshot();
    logic [7:0] exp_cat;
    logic [3:0] exp_an;
    int c, d, s;
    lz = 1'b0; val = 16'h1111; dp = 4'h0; en = 4'hF; bright = 4'hF;
    align_frame();
    for (int n = 0; n < 64; n++) begin
      tick();
      c = (cyc - 1) % 32; d = c / 8; s = c % 8;
      exp_an = 4'hF; exp_cat = 8'hFF;
      if (s >= 2) begin
        exp_an  = 4'(~(4'b0001 << d));
        exp_cat = (n < 32) ? 8'h9F : 8'h25;
      end
      checks++;
      if (an !== exp_an || cat !== exp_cat) begin
        errors++;
        $display("FAIL snapshot cyc=%0d an=%h cat=%h expected an=%h cat=%h",
                 cyc, an, cat, exp_an, exp_cat);
      end
      if (n == 20) val = 16'h2222;
    end
  endtask

  // Async reset while digit 0 is lit; outputs clear before the next edge,
  // then scanning restarts at digit 0 with the new value 0003.
  task automatic test_async_reset();
    logic [7:0] exp_cat;
    logic [3:0] exp_an;
    int c, d, s;
    lz = 1'b0; val = 16'h7777; dp = 4'h0; en = 4'hF; bright = 4'hF;
    align_frame();
    repeat (5) tick();
    checks++;
    if (an !== 4'hE || cat !== 8'h1F) begin
      errors++;
      $display("FAIL pre_reset_lit an=%h cat=%h expected an=e cat=1f", an, cat);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF || cat !== 8'hFF || tick_o !== 1'b0 || idx_o !== 2'd0) begin
      errors++;
      $display("FAIL async_reset an=%h cat=%h tick=%b idx=%0d expected an=f cat=ff tick=0 idx=0",
               an, cat, tick_o, idx_o);
    end
    val = 16'h0003;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int n = 0; n < 32; n++) begin
      tick();
      c = (cyc - 1) % 32; d = c / 8; s = c % 8;
      exp_an = 4'hF; exp_cat = 8'hFF;
      if (s >= 2) begin
        exp_an  = 4'(~(4'b0001 << d));
        exp_cat = (d == 0) ? 8'h0D : 8'h03;
      end
      checks++;
      if (an !== exp_an || cat !== exp_cat || idx_o !== 2'(d) || tick_o !== 1'b0) begin
        errors++;
        $display("FAIL restart cyc=%0d an=%h cat=%h idx=%0d tick=%b expected an=%h cat=%h idx=%0d tick=0",
                 cyc, an, cat, idx_o, tick_o, exp_an, exp_cat, d);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_scan_decode();
    test_frame_tick();
    test_lz_blank();
    test_enable_mask();
    test_pwm();
    test_snapshot();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
